c_seq_descrambler: RTL and testbench
====================================

Name: c_seq_descrambler

Overview:
- Receive-side counterpart of the Gold-sequence scrambler used on the PUCCH transmit path (TS 38.211 5.2.1 / 6.3.2.5.1).
- Takes soft LLRs for one codeword and applies the c(n) sequence as a sign flip. An LLR is negated where c(n)=1 and passed through where c(n)=0.
- Sits between the demodulator/LLR stage and the channel decoder.
- Processes N_PAR LLRs per beat over valid/ready streams on both sides.

Parameters:
- N_PAR, 8, LLRs per beat; also the Gold generator output width per step.
- LLR_W, 8, signed LLR width in two's complement.
- LEN_W, 16, width of the codeword length in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_load  in  1  one-cycle pulse: start a codeword; capture i_init and i_len
- i_init  in  31  c_init for x2
- i_len  in  LEN_W  codeword length in LLRs; must be ≥1
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&s_ready
- s_llr  in  N_PAR*LLR_W  lane k at bits [k*LLR_W +: LLR_W]; lane 0 = lowest n
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_llr  out  N_PAR*LLR_W  descrambled LLRs
- m_last  out  1  final beat of codeword
- o_busy  out  1  codeword in progress: state≠IDLE or m_valid

Behaviour:
- c(n) = x1(n+1600) XOR x2(n+1600).
  - x1 initialised to 1 followed by 30 zeros; x2 initialised to i_init.
- Beat j uses c(j*N_PAR+k) on lane k.
- Reset values: all outputs 0, m_llr=0, state IDLE.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: s_ready=0. On i_load, capture i_init and i_len, set remaining count rem=i_len, load the generator, go to PRIME.
  - PRIME: one cycle. Register the first N_PAR c bits into c_word, advance the generator, go to RUN.
  - RUN: s_ready = !m_valid | m_ready.
    - On accept: m_llr lane k = c_word[k] ? neg_sat(s_llr[k]) : s_llr[k].
    - Set m_valid=1, m_last=(rem≤N_PAR), rem -= N_PAR, load the next c_word, advance the generator.
    - After the beat with m_last is accepted on input, return to IDLE.
- neg_sat(x): -x, except the most negative value maps to the most positive value (-128 → +127 for LLR_W=8).
- Partial last beat: lanes k ≥ rem are output as 0 and their c bits are consumed but ignored.
- Latency: 1 cycle from input accept to m_valid.
- Backpressure: m_llr and m_last hold stable while m_valid & !m_ready.
- Throughput: 1 beat/cycle with m_ready=1.
- i_load while not IDLE is ignored; i_load in the same cycle the last beat is accepted is also ignored.
- s_valid in IDLE/PRIME is not accepted (s_ready=0).
- i_len=0 is illegal: the block treats it as 1.
- rem is LEN_W+1 bits wide to avoid wrap at i_len=2^LEN_W-1.
- Reset mid-codeword: immediate return to IDLE; m_valid drops; generator state is discarded.

Optional Feature:
- Macro C_DESCR_BYPASS_EN.
- Defined:
  - Adds input port i_bypass (1 bit), sampled at i_load.
  - When captured as 1, m_llr = s_llr unchanged (no negation, no saturation). Lane zeroing on the last beat still applies.
  - FSM timing is identical.
- Undefined: port absent; descrambling always applied.

Decomposition:
- Package c_seq_pkg:
  - constant NC=1600
  - typedef of the state enum {IDLE, PRIME, RUN}
  - function neg_sat parameterised by LLR_W
- Sub-module: the existing c_seq_gen instantiated with nGenBit=N_PAR, driven by i_load/i_en from the FSM.
  - c_word is captured from its o_seq_bit one cycle after load/en (when o_valid is 1).

Test Plan:
- init=0x12345678, len=64, all LLR=+20, m_ready=1 → 8 beats at 1/cycle; lane value is -20 where the golden-model c(n)=1 and +20 otherwise; m_last only on beat 8.
- len=13, N_PAR=8, LLR=+7 → 2 beats; beat 2 lanes 5..7 = 0; m_last=1 on beat 2; o_busy falls the cycle after the m_last handshake.
- Input -128 on a lane with c=1 → output +127; input +127 with c=1 → -127.
- Random m_ready (50%) with len=256 → output equals the golden model with no lost or duplicate beats; m_llr is stable while stalled.
- rst_n asserted at beat 3 of len=64, then a new i_load with init=0 → clean restart; first output matches c(0..7) for init=0.
- With C_DESCR_BYPASS_EN and i_bypass=1, LLR=-33 → output -33 on every lane.

Source files
------------

// File: rtl/c_seq_descrambler_pkg.sv
// c_seq_pkg: shared constants, FSM state type and LLR negation helper for the descrambler
// Contents: NC (Gold sequence offset), state_t {IDLE, PRIME, RUN}, neg_sat()
package c_seq_pkg;
    localparam int NC = 1600;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    // x is a w-bit two's complement value sign-extended to 32 bits; the most
    // negative value has no positive counterpart, so it saturates to the max.
    function automatic logic signed [31:0] neg_sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] mx;
        mx = (32'sd1 <<< (w - 1)) - 32'sd1;
        return (x == -mx - 32'sd1) ? mx : -x;
    endfunction
endpackage

// File: rtl/c_seq_descrambler_if.sv
// c_seq_descrambler_if: input and output LLR streams of the descrambler
// Signals: s_valid/s_ready/s_llr (input beat), m_valid/m_ready/m_llr/m_last (output beat)
// Modports: slave (descrambler side), master (source/sink side)
interface c_seq_descrambler_if #(
    parameter int N_PAR = 8,
    parameter int LLR_W = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [N_PAR*LLR_W-1:0]   s_llr;
    logic                     m_valid;
    logic                     m_ready;
    logic [N_PAR*LLR_W-1:0]   m_llr;
    logic                     m_last;
    modport slave (input s_valid, s_llr, m_ready, output s_ready, m_valid, m_llr, m_last);
    modport master (output s_valid, s_llr, m_ready, input s_ready, m_valid, m_llr, m_last);
endinterface

// File: rtl/c_seq_descrambler_gen.sv
// c_seq_gen: Gold sequence generator c(n) = x1(n+NC) ^ x2(n+NC), nGenBit bits per step
// Ports: clk, rst_n, i_load (load x1=1, x2=i_init, pre-advanced by NC),
//        i_en (emit next nGenBit bits), o_seq_bit (bit k = c(n+k)), o_valid
module c_seq_gen
    import c_seq_pkg::*;
#(
    parameter int nGenBit = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [30:0]        i_init,
    input  logic               i_en,
    output logic [nGenBit-1:0] o_seq_bit,
    output logic               o_valid
);
    // bit i of each register holds x(n+i) for the current position n
    logic [30:0] x1, x2, x1_ld, x2_ld, x1_nx, x2_nx;
    // The NC-step skip is a fixed linear map of i_init; the loop flattens to an XOR network.
    always_comb begin
        x1_ld = 31'd1;
        x2_ld = i_init;
        for (int i = 0; i < NC; i++) begin
            x1_ld = {x1_ld[3] ^ x1_ld[0], x1_ld[30:1]};
            x2_ld = {x2_ld[3] ^ x2_ld[2] ^ x2_ld[1] ^ x2_ld[0], x2_ld[30:1]};
        end
        x1_nx = x1;
        x2_nx = x2;
        for (int i = 0; i < nGenBit; i++) begin
            x1_nx = {x1_nx[3] ^ x1_nx[0], x1_nx[30:1]};
            x2_nx = {x2_nx[3] ^ x2_nx[2] ^ x2_nx[1] ^ x2_nx[0], x2_nx[30:1]};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1        <= '0;
            x2        <= '0;
            o_seq_bit <= '0;
            o_valid   <= 1'b0;
        end else if (i_load) begin
            x1      <= x1_ld;
            x2      <= x2_ld;
            o_valid <= 1'b0;
        end else if (i_en) begin
            o_seq_bit <= x1[nGenBit-1:0] ^ x2[nGenBit-1:0];
            x1        <= x1_nx;
            x2        <= x2_nx;
            o_valid   <= 1'b1;
        end
    end
endmodule

// File: rtl/c_seq_descrambler.sv
// c_seq_descrambler: sign-flips soft LLRs by the Gold sequence c(n) for one codeword
// Ports: clk, rst_n (async, active low), i_load/i_init/i_len (codeword start),
//        bus (slave: s_* input stream, m_* output stream), o_busy.
// Option: define C_DESCR_BYPASS_EN to add i_bypass (sampled at i_load; passes LLRs unchanged).
module c_seq_descrambler
    import c_seq_pkg::*;
#(
    parameter int N_PAR = 8,
    parameter int LLR_W = 8,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [30:0]          i_init,
    input  logic [LEN_W-1:0]     i_len,
`ifdef C_DESCR_BYPASS_EN
    input  logic                 i_bypass,
`endif
    c_seq_descrambler_if.slave   bus,
    output logic                 o_busy
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PRIME = PRIME;
    localparam logic [1:0] ST_RUN = RUN;
    localparam logic [LEN_W:0] NP = (LEN_W+1)'(N_PAR);
    logic [1:0]             st;
    logic [LEN_W:0]         rem;
    logic [N_PAR-1:0]       c_word;
    logic                   c_ok, ld, acc, last;
    logic [N_PAR*LLR_W-1:0] nxt_llr;
`ifdef C_DESCR_BYPASS_EN
    logic byp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byp <= 1'b0;
        else if (ld) byp <= i_bypass;
    end
`else
    logic byp;
    assign byp = 1'b0;
`endif
    assign ld = i_load && st == ST_IDLE;
    assign bus.s_ready = st == ST_RUN && c_ok && (!bus.m_valid || bus.m_ready);
    assign acc = bus.s_valid && bus.s_ready;
    assign last = rem <= NP;
    assign o_busy = st != ST_IDLE || bus.m_valid;
    c_seq_gen #(.nGenBit(N_PAR)) u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (ld),
        .i_init    (i_init),
        .i_en      (st == ST_PRIME || acc),
        .o_seq_bit (c_word),
        .o_valid   (c_ok)
    );
    // lanes at or beyond the remaining count belong to no codeword bit and are zeroed
    for (genvar k = 0; k < N_PAR; k++) begin : g_lane
        logic signed [LLR_W-1:0] x;
        assign x = bus.s_llr[k*LLR_W +: LLR_W];
        assign nxt_llr[k*LLR_W +: LLR_W] = ((LEN_W+1)'(k) >= rem) ? '0 :
            (byp || !c_word[k]) ? x : LLR_W'(neg_sat(32'(x), LLR_W));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_IDLE;
            rem         <= '0;
            bus.m_valid <= 1'b0;
            bus.m_llr   <= '0;
            bus.m_last  <= 1'b0;
        end else begin
            if (bus.m_ready) bus.m_valid <= 1'b0;
            if (ld) begin
                st  <= ST_PRIME;
                rem <= (i_len == '0) ? (LEN_W+1)'(1) : {1'b0, i_len};
            end
            if (st == ST_PRIME) st <= ST_RUN;
            if (acc) begin
                bus.m_valid <= 1'b1;
                bus.m_llr   <= nxt_llr;
                bus.m_last  <= last;
                rem         <= rem - NP;
                if (last) st <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_c_seq_descrambler.sv
// tb_c_seq_descrambler: randomized self-checking bench against a sequence-level Gold model
module tb_c_seq_descrambler;
    localparam int N_PAR = 8;
    localparam int LLR_W = 8;
    localparam int LEN_W = 16;
    localparam int W = N_PAR * LLR_W;
    localparam int NC = 1600;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_load = 1'b0;
    logic [30:0]      i_init = '0;
    logic [LEN_W-1:0] i_len = '0;
    logic             o_busy;
`ifdef C_DESCR_BYPASS_EN
    logic             i_bypass = 1'b0;
`endif

    c_seq_descrambler_if #(.N_PAR(N_PAR), .LLR_W(LLR_W)) bus();

    c_seq_descrambler #(.N_PAR(N_PAR), .LLR_W(LLR_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (i_load),
        .i_init   (i_init),
        .i_len    (i_len),
`ifdef C_DESCR_BYPASS_EN
        .i_bypass (i_bypass),
`endif
        .bus      (bus),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    bit x1 [0:2200];
    bit x2 [0:2200];
    bit cref [0:511];

    logic [W-1:0] in_q[$];
    logic [W-1:0] got_llr[$];
    bit           got_last[$];
    int           got_cyc[$];
    int           stall_err;
    int           busy_err;

    // Gold sequence straight from the recurrences: x1(n+31)=x1(n+3)+x1(n), x2(n+31)=x2(n+3)+x2(n+2)+x2(n+1)+x2(n)
    task automatic gen_ref(input logic [30:0] init, input int count);
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = init[i];
        end
        for (int n = 0; n + 31 < NC + count; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int n = 0; n < count; n++) cref[n] = x1[n+NC] ^ x2[n+NC];
    endtask

    function automatic logic [W-1:0] exp_beat(input int j, input logic [W-1:0] d, input int len, input bit byp);
        int lim;
        int v;
        int n;
        lim = 1 << (LLR_W - 1);
        exp_beat = '0;
        for (int k = 0; k < N_PAR; k++) begin
            n = j * N_PAR + k;
            v = $signed(d[k*LLR_W +: LLR_W]);
            if (n < len) begin
                if (!byp && cref[n]) v = (-v > lim - 1) ? lim - 1 : -v;
                exp_beat[k*LLR_W +: LLR_W] = v[LLR_W-1:0];
            end
        end
    endfunction

    function automatic logic [W-1:0] all_lanes(input logic [LLR_W-1:0] v);
        all_lanes = {N_PAR{v}};
    endfunction

    // drives one codeword from in_q and records every output handshake; noise pulses i_load while busy
    task automatic run_cw(input logic [30:0] init, input int len, input int rdy, input int vld, input bit noise);
        int nb;
        int ii;
        int cyc;
        bit held_v;
        logic [W:0] held;
        nb = (len == 0) ? 1 : (len + N_PAR - 1) / N_PAR;
        ii = 0;
        cyc = 0;
        held_v = 0;
        held = '0;
        stall_err = 0;
        busy_err = 0;
        got_llr.delete();
        got_last.delete();
        got_cyc.delete();
        gen_ref(init, nb * N_PAR);
        @(negedge clk);
        i_init = init;
        i_len = LEN_W'(len);
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        while (got_llr.size() < nb && cyc < 5000) begin
            bus.s_valid = (ii < nb) && ($urandom_range(99) < vld);
            bus.s_llr = (ii < nb) ? in_q[ii] : '0;
            bus.m_ready = $urandom_range(99) < rdy;
            i_load = noise && (ii < nb) && ($urandom_range(3) == 0);
            if (i_load) i_init = 31'($urandom);
            #1;
            if (held_v && {bus.m_last, bus.m_llr} !== held) stall_err++;
            if (!o_busy) busy_err++;
            if (bus.m_valid && bus.m_ready) begin
                got_llr.push_back(bus.m_llr);
                got_last.push_back(bus.m_last);
                got_cyc.push_back(cyc);
            end
            held_v = bus.m_valid && !bus.m_ready;
            held = {bus.m_last, bus.m_llr};
            if (bus.s_valid && bus.s_ready) ii++;
            @(negedge clk);
            cyc++;
        end
        i_load = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_llr = '0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({bus.m_valid, bus.m_last, bus.s_ready, o_busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got {m_valid,m_last,s_ready,o_busy}=%b exp 0000", {bus.m_valid, bus.m_last, bus.s_ready, o_busy});
        end
        n_checks++;
        if (bus.m_llr !== '0) begin
            n_fail++;
            $display("FAIL reset_llr got %h exp 0", bus.m_llr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.s_valid = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.s_ready, o_busy} !== 2'b0) begin
            n_fail++;
            $display("FAIL idle_ready got {s_ready,o_busy}=%b exp 00", {bus.s_ready, o_busy});
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        in_q.delete();
        for (int j = 0; j < 8; j++) in_q.push_back(all_lanes(8'd20));
        run_cw(31'h12345678, 64, 100, 100, 0);
        n_checks++;
        if (got_llr.size() != 8) begin
            n_fail++;
            $display("FAIL basic_count got %0d exp 8", got_llr.size());
        end
        for (int j = 0; j < got_llr.size(); j++) begin
            e = exp_beat(j, in_q[j], 64, 0);
            n_checks++;
            if (got_llr[j] !== e) begin
                n_fail++;
                $display("FAIL basic_llr beat %0d got %h exp %h", j, got_llr[j], e);
            end
            n_checks++;
            if (got_last[j] !== (j == 7)) begin
                n_fail++;
                $display("FAIL basic_last beat %0d got %b exp %b", j, got_last[j], j == 7);
            end
        end
        if (got_cyc.size() == 8) begin
            n_checks++;
            if (got_cyc[0] != 2 || got_cyc[7] - got_cyc[0] != 7) begin
                n_fail++;
                $display("FAIL basic_timing got first=%0d span=%0d exp first=2 span=7", got_cyc[0], got_cyc[7] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_partial();
        logic [W-1:0] e;
        in_q.delete();
        for (int j = 0; j < 2; j++) in_q.push_back(all_lanes(8'd7));
        run_cw(31'($urandom), 13, 100, 100, 0);
        #1;
        n_checks++;
        if ({o_busy, bus.m_valid, bus.s_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL partial_busy got {o_busy,m_valid,s_ready}=%b exp 000", {o_busy, bus.m_valid, bus.s_ready});
        end
        n_checks++;
        if (got_llr.size() != 2 || busy_err != 0) begin
            n_fail++;
            $display("FAIL partial_count got %0d beats busy_err=%0d exp 2 beats busy_err=0", got_llr.size(), busy_err);
        end
        for (int j = 0; j < got_llr.size(); j++) begin
            e = exp_beat(j, in_q[j], 13, 0);
            n_checks++;
            if (got_llr[j] !== e || got_last[j] !== (j == 1)) begin
                n_fail++;
                $display("FAIL partial_beat %0d got %h last %b exp %h last %b", j, got_llr[j], got_last[j], e, j == 1);
            end
        end
        if (got_llr.size() == 2) begin
            n_checks++;
            if (got_llr[1][W-1:5*LLR_W] !== '0) begin
                n_fail++;
                $display("FAIL partial_zero lanes5_7 got %h exp 0", got_llr[1][W-1:5*LLR_W]);
            end
        end
        in_q.delete();
        in_q.push_back(all_lanes(8'd9));
        run_cw(31'($urandom), 0, 100, 100, 0);
        e = exp_beat(0, in_q[0], 1, 0);
        n_checks++;
        if (got_llr.size() != 1 || got_llr[0] !== e || got_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL len0 got %0d beats %h exp 1 beat %h last 1", got_llr.size(), got_llr.size() ? got_llr[0] : '0, e);
        end
    endtask

    task automatic test_sat();
        logic [30:0] init;
        logic [W-1:0] d;
        logic [LLR_W-1:0] g;
        int ones;
        bit alt;
        do begin
            init = 31'($urandom);
            gen_ref(init, N_PAR);
            ones = 0;
            for (int k = 0; k < N_PAR; k++) ones += cref[k];
        end while (ones < 2);
        alt = 0;
        for (int k = 0; k < N_PAR; k++) begin
            d[k*LLR_W +: LLR_W] = cref[k] ? (alt ? 8'h7f : 8'h80) : LLR_W'($urandom);
            if (cref[k]) alt = !alt;
        end
        in_q.delete();
        in_q.push_back(d);
        run_cw(init, 8, 100, 100, 0);
        n_checks++;
        if (got_llr.size() != 1) begin
            n_fail++;
            $display("FAIL sat_count got %0d exp 1", got_llr.size());
        end else begin
            for (int k = 0; k < N_PAR; k++) begin
                if (cref[k]) begin
                    g = got_llr[0][k*LLR_W +: LLR_W];
                    n_checks++;
                    if (g !== (d[k*LLR_W +: LLR_W] == 8'h80 ? 8'h7f : 8'h81)) begin
                        n_fail++;
                        $display("FAIL sat_lane %0d in %h got %h exp %h", k, d[k*LLR_W +: LLR_W], g, d[k*LLR_W +: LLR_W] == 8'h80 ? 8'h7f : 8'h81);
                    end
                end
            end
            n_checks++;
            if (got_llr[0] !== exp_beat(0, d, 8, 0)) begin
                n_fail++;
                $display("FAIL sat_beat got %h exp %h", got_llr[0], exp_beat(0, d, 8, 0));
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        in_q.delete();
        for (int j = 0; j < 32; j++) in_q.push_back({$urandom, $urandom});
        run_cw(31'($urandom), 256, 50, 70, 1);
        n_checks++;
        if (got_llr.size() != 32 || stall_err != 0 || busy_err != 0) begin
            n_fail++;
            $display("FAIL random_flow got beats=%0d stall_err=%0d busy_err=%0d exp 32/0/0", got_llr.size(), stall_err, busy_err);
        end
        for (int j = 0; j < got_llr.size(); j++) begin
            e = exp_beat(j, in_q[j], 256, 0);
            n_checks++;
            if (got_llr[j] !== e || got_last[j] !== (j == 31)) begin
                n_fail++;
                $display("FAIL random_beat %0d got %h last %b exp %h last %b", j, got_llr[j], got_last[j], e, j == 31);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        @(negedge clk);
        i_init = 31'($urandom);
        i_len = LEN_W'(64);
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_llr = {$urandom, $urandom};
        bus.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre m_valid got %b exp 1", bus.m_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_valid, o_busy, bus.s_ready} !== 3'b0 || bus.m_llr !== '0) begin
            n_fail++;
            $display("FAIL midrst got {m_valid,o_busy,s_ready}=%b llr %h exp 000 llr 0", {bus.m_valid, o_busy, bus.s_ready}, bus.m_llr);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_q.delete();
        in_q.push_back({$urandom, $urandom});
        run_cw(31'd0, 8, 100, 100, 0);
        e = exp_beat(0, in_q[0], 8, 0);
        n_checks++;
        if (got_llr.size() != 1 || got_llr[0] !== e) begin
            n_fail++;
            $display("FAIL midrst_restart got %0d beats %h exp 1 beat %h", got_llr.size(), got_llr.size() ? got_llr[0] : '0, e);
        end
    endtask

`ifdef C_DESCR_BYPASS_EN
    task automatic test_bypass();
        i_bypass = 1'b1;
        in_q.delete();
        for (int j = 0; j < 2; j++) in_q.push_back(all_lanes(8'hdf));
        run_cw(31'($urandom), 16, 100, 100, 0);
        i_bypass = 1'b0;
        n_checks++;
        if (got_llr.size() != 2) begin
            n_fail++;
            $display("FAIL bypass_count got %0d exp 2", got_llr.size());
        end
        for (int j = 0; j < got_llr.size(); j++) begin
            n_checks++;
            if (got_llr[j] !== all_lanes(8'hdf)) begin
                n_fail++;
                $display("FAIL bypass_beat %0d got %h exp %h", j, got_llr[j], all_lanes(8'hdf));
            end
        end
    endtask
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_llr = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_sat();
        test_random();
        test_reset_mid();
`ifdef C_DESCR_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
